// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipelined RISC-V core.
//   NOP_INSTR : canonical bubble encoding, addi x0,x0,0
//   if_id_t   : IF/ID payload as seen by the 32-bit core
package riscv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, q -> 0
//   inc  : count up by one unless already at EN
//   clr  : synchronous clear (lower priority than rst, higher than inc)
//   q    : count value
// EN is the saturation ceiling; the counter holds there instead of wrapping.
module sat_counter #(
    parameter int           W  = 16,
    parameter logic [W-1:0] EN = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != EN))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with hazard control and debug counters.
//   clk, rst                      : clock, synchronous active-high reset
//   stall_d, flush_d              : hazard unit hold / bubble request (flush wins)
//   valid_f, pc_in, instr_in,
//   pc_plusF                      : fetch-stage payload
//   pc_out, instr_out,
//   pc_plus4_reg, valid_d         : registered payload to decode
//   stall_cnt, flush_cnt          : saturating event counters
//   stall_timeout                 : sticky, STALL_LIMIT consecutive stalls seen
module if_id_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] NOP_INSTR   = riscv_pipe_pkg::NOP_INSTR,
    parameter int          CNT_W       = 16,
    parameter int          STALL_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             valid_f,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_plusF,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_plus4_reg,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc_plus4;
        logic             valid;
    } pl_t;

    localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(NOP_INSTR);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_1 = CNT_W'(STALL_LIMIT - 1);

    localparam pl_t BUBBLE = '{pc: '0, instr: NOP_W, pc_plus4: '0, valid: 1'b0};

    // flush overrides stall, so a stall only counts when no flush is present
    logic stall_only;
    logic load;
    logic [CNT_W-1:0] cons;
    pl_t  pl_q;

    assign stall_only = stall_d && !flush_d;
    assign load       = !stall_d && !flush_d;

    always_ff @(posedge clk) begin
        if (rst || flush_d)
            pl_q <= BUBBLE;
        else if (load) begin
            pl_q.pc       <= pc_in;
            pl_q.pc_plus4 <= pc_plusF;
            pl_q.valid    <= valid_f;
            // invalid fetch slots enter decode as a NOP so decode never sees garbage
            pl_q.instr    <= valid_f ? instr_in : NOP_W;
        end
    end

    assign pc_out       = pl_q.pc;
    assign instr_out    = pl_q.instr;
    assign pc_plus4_reg = pl_q.pc_plus4;
    assign valid_d      = pl_q.valid;

    sat_counter #(.W(CNT_W), .EN('1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_only),
        .clr (1'b0),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W), .EN('1)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_d),
        .clr (1'b0),
        .q   (flush_cnt)
    );

    // consecutive-stall run length; any non-stall cycle ends the run
    sat_counter #(.W(CNT_W), .EN(LIMIT)) u_cons (
        .clk (clk),
        .rst (rst),
        .inc (stall_only),
        .clr (!stall_only),
        .q   (cons)
    );

    // set on the edge where cons reaches LIMIT; sticky until reset
    always_ff @(posedge clk) begin
        if (rst)
            stall_timeout <= 1'b0;
        else if (stall_only && (cons >= LIMIT_1))
            stall_timeout <= 1'b1;
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

    localparam int LIM  = 4;
    localparam int CMAX = 7;

    logic        clk = 1'b0;
    logic        rst, stall_d, flush_d, valid_f;
    logic [31:0] pc_in, instr_in, pc_plusF;
    logic [31:0] pc_out, instr_out, pc_plus4_reg;
    logic        valid_d, stall_timeout;
    logic [2:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // reference state, kept as plain integers / flags
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_to;
    int          m_stall, m_flush, m_run;

    if_id_pipe_reg #(
        .WIDTH(32), .NOP_INSTR(32'h0000_0013), .CNT_W(3), .STALL_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
        .valid_f(valid_f), .pc_in(pc_in), .instr_in(instr_in), .pc_plusF(pc_plusF),
        .pc_out(pc_out), .instr_out(instr_out), .pc_plus4_reg(pc_plus4_reg),
        .valid_d(valid_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // apply one cycle of inputs, clock it, and advance the reference model
    task automatic step(input bit r, input bit f, input bit s, input bit v,
                        input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4);
        rst = r; flush_d = f; stall_d = s; valid_f = v;
        pc_in = p; instr_in = i; pc_plusF = p4;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_instr = 32'h13; m_pc4 = 0; m_valid = 0;
            m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
        end else if (f) begin
            m_pc = 0; m_instr = 32'h13; m_pc4 = 0; m_valid = 0;
            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            m_run = 0;
        end else if (s) begin
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            m_run = m_run + 1;
            if (m_run >= LIM) m_to = 1;
        end else begin
            m_pc = p; m_pc4 = p4; m_valid = v;
            m_instr = v ? i : 32'h13;
            m_run = 0;
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 1, 32'h100, 32'h00500093, 32'h104);
        step(1, 0, 0, 1, 32'h100, 32'h00500093, 32'h104);
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        checks++; if (instr_out !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=13", instr_out); end
        checks++; if (pc_plus4_reg !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", pc_plus4_reg); end
        checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
        checks++; if ({stall_cnt, flush_cnt, stall_timeout} !== 7'b0) begin failures++;
            $display("FAIL reset_dbg got=%0d/%0d/%b exp=0/0/0", stall_cnt, flush_cnt, stall_timeout); end
        step(0, 0, 0, 1, 32'h100, 32'h00500093, 32'h104);
        checks++; if ({pc_out, instr_out, pc_plus4_reg, valid_d} !== {32'h100, 32'h00500093, 32'h104, 1'b1}) begin
            failures++; $display("FAIL first_load got=%h/%h/%h/%b exp=100/00500093/104/1", pc_out, instr_out, pc_plus4_reg, valid_d); end
    endtask

    task automatic test_stall_hold();
        step(0, 0, 0, 1, 32'h200, 32'h00a00113, 32'h204);
        step(0, 0, 1, 1, 32'h204, 32'h11111111, 32'h208);
        step(0, 0, 1, 1, 32'h208, 32'h22222222, 32'h20c);
        step(0, 0, 1, 1, 32'h20c, 32'h33333333, 32'h210);
        checks++; if ({pc_out, instr_out, pc_plus4_reg, valid_d} !== {32'h200, 32'h00a00113, 32'h204, 1'b1}) begin
            failures++; $display("FAIL stall_hold got=%h/%h/%h/%b exp=200/00a00113/204/1", pc_out, instr_out, pc_plus4_reg, valid_d); end
        checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL stall_no_timeout got=%b exp=0", stall_timeout); end
    endtask

    task automatic test_flush_beats_stall();
        step(0, 1, 1, 1, 32'h400, 32'h44444444, 32'h404);
        checks++; if ({pc_out, instr_out, pc_plus4_reg, valid_d} !== {32'h0, 32'h13, 32'h0, 1'b0}) begin
            failures++; $display("FAIL flush_bubble got=%h/%h/%h/%b exp=0/13/0/0", pc_out, instr_out, pc_plus4_reg, valid_d); end
        checks++; if (flush_cnt !== 3'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_invalid_fetch();
        step(0, 0, 0, 0, 32'h300, 32'hffffffff, 32'h304);
        checks++; if ({pc_out, instr_out, pc_plus4_reg, valid_d} !== {32'h300, 32'h13, 32'h304, 1'b0}) begin
            failures++; $display("FAIL invalid_fetch got=%h/%h/%h/%b exp=300/13/304/0", pc_out, instr_out, pc_plus4_reg, valid_d); end
    endtask

    task automatic test_watchdog();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 32'h500, 32'h1, 32'h504);
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_run3 got=%b exp=0", stall_timeout); end
        step(0, 0, 0, 1, 32'h500, 32'h1, 32'h504);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 32'h600, 32'h2, 32'h604);
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_run2_3 got=%b exp=0", stall_timeout); end
        step(0, 0, 1, 1, 32'h600, 32'h2, 32'h604);
        checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_run2_4 got=%b exp=1", stall_timeout); end
        step(0, 1, 0, 1, 32'h600, 32'h2, 32'h604);
        step(0, 0, 0, 1, 32'h700, 32'h3, 32'h704);
        checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout); end
        step(1, 0, 0, 1, 32'h700, 32'h3, 32'h704);
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_reset got=%b exp=0", stall_timeout); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 1, 32'h800, 32'h5, 32'h804);
            checks++; if (flush_cnt !== 3'((k + 1 < 7) ? k + 1 : 7)) begin failures++;
                $display("FAIL flush_sat[%0d] got=%0d exp=%0d", k, flush_cnt, (k + 1 < 7) ? k + 1 : 7); end
        end
        for (int k = 0; k < 9; k++) step(0, 0, 1, 1, 32'h900, 32'h6, 32'h904);
        checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL stall_sat got=%0d exp=7", stall_cnt); end
        // reset with stall and flush both requested: they must be ignored
        step(1, 1, 1, 1, 32'ha00, 32'h7, 32'ha04);
        checks++; if ({stall_cnt, flush_cnt, stall_timeout, valid_d, instr_out} !== {3'd0, 3'd0, 1'b0, 1'b0, 32'h13}) begin
            failures++; $display("FAIL sat_reset got=%0d/%0d/%b/%b/%h exp=0/0/0/0/13", stall_cnt, flush_cnt, stall_timeout, valid_d, instr_out); end
        step(1, 0, 1, 1, 32'ha00, 32'h7, 32'ha04);
        step(1, 1, 0, 1, 32'ha00, 32'h7, 32'ha04);
        checks++; if ({stall_cnt, flush_cnt} !== 6'd0) begin failures++; $display("FAIL sat_reset3 got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
            checks++;
            if ({pc_out, instr_out, pc_plus4_reg, valid_d, stall_cnt, flush_cnt, stall_timeout} !==
                {m_pc, m_instr, m_pc4, m_valid, 3'(m_stall), 3'(m_flush), m_to}) begin
                failures++;
                $display("FAIL random[%0d] got=%h/%h/%h/%b/%0d/%0d/%b exp=%h/%h/%h/%b/%0d/%0d/%b", n,
                         pc_out, instr_out, pc_plus4_reg, valid_d, stall_cnt, flush_cnt, stall_timeout,
                         m_pc, m_instr, m_pc4, m_valid, m_stall, m_flush, m_to);
            end
        end
    endtask

    initial begin
        rst = 1; stall_d = 0; flush_d = 0; valid_f = 0;
        pc_in = 0; instr_in = 0; pc_plusF = 0;
        test_reset();
        test_stall_hold();
        test_flush_beats_stall();
        test_invalid_fetch();
        test_watchdog();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register for the pipelined RISC-V core. Adds three features:
- stall (hold) and flush (bubble injection) under hazard-unit control;
- a valid bit carried with the payload;
- saturating stall/flush event counters and a consecutive-stall watchdog for debug.

It sits between the fetch stage (PC, instruction memory, PC+4 adder) and the decode stage (register file, control, immediate generator).

Parameters:
- WIDTH, 32, width of PC, instruction and PC+4 fields.
- NOP_INSTR, 32'h0000_0013, encoding injected on flush/reset (addi x0,x0,0); only the low WIDTH bits are used.
- CNT_W, 16, width of the stall and flush event counters.
- STALL_LIMIT, 64, consecutive stall cycles that raise stall_timeout; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall_d  in  1  hazard unit: hold current IF/ID contents.
- flush_d  in  1  hazard unit: replace IF/ID contents with a bubble (taken branch/jump).
- valid_f  in  1  fetch stage presents a real instruction this cycle.
- pc_in  in  WIDTH  fetch PC.
- instr_in  in  WIDTH  fetched instruction.
- pc_plusF  in  WIDTH  fetch PC+4.
- pc_out  out  WIDTH  registered PC to decode.
- instr_out  out  WIDTH  registered instruction to decode.
- pc_plus4_reg  out  WIDTH  registered PC+4 to decode.
- valid_d  out  1  registered valid to decode.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total flush events, saturating.
- stall_timeout  out  1  sticky; set when consecutive stall cycles reach STALL_LIMIT.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - pc_out = 0, instr_out = NOP_INSTR, pc_plus4_reg = 0, valid_d = 0;
  - stall_cnt = 0, flush_cnt = 0, stall_timeout = 0;
  - internal consecutive-stall counter cons = 0.
- Priority per cycle: rst > flush_d > stall_d > normal load.
- Flush (flush_d = 1, regardless of stall_d):
  - pc_out = 0, pc_plus4_reg = 0, instr_out = NOP_INSTR, valid_d = 0;
  - flush_cnt increments (saturates at all-ones);
  - cons clears to 0.
- Stall (stall_d = 1, flush_d = 0):
  - payload and valid_d hold;
  - stall_cnt increments (saturates);
  - cons increments, saturating at STALL_LIMIT.
- Normal load:
  - pc_out <= pc_in, instr_out <= instr_in, pc_plus4_reg <= pc_plusF, valid_d <= valid_f;
  - if valid_f = 0, instr_out loads NOP_INSTR instead of instr_in (pc fields still load);
  - cons clears to 0.
- Latency: one cycle from fetch inputs to decode outputs. Outputs are pure register Q (no combinational path from inputs).
- Watchdog:
  - stall_timeout sets on the clock edge at which cons becomes STALL_LIMIT, i.e. after STALL_LIMIT consecutive stall cycles;
  - it stays set until rst. Flush and normal load do not clear it.
- Counter saturation: at 2^CNT_W-1 a counter holds; no wrap.
- Simultaneous stall_d and flush_d: flush wins. Only flush_cnt increments; stall_cnt does not.
- Reset asserted mid-stall or mid-flush: the reset values apply on that edge; the stall/flush inputs are ignored.

Decomposition:
- Package riscv_pipe_pkg holds:
  - NOP_INSTR constant (32'h0000_0013);
  - typedef struct packed if_id_t {pc, instr, pc_plus4, valid} with WIDTH fixed at 32 for core use.
- One sub-module, sat_counter (parameters W and EN; ports clk, rst, inc, clr, q), instanced three times: stall_cnt, flush_cnt, and cons (with its max set to STALL_LIMIT).

Test Plan:
- Reset then load: rst for 2 cycles, then pc_in = 0x100, instr_in = 0x00500093, pc_plusF = 0x104, valid_f = 1 -> after reset, outputs are 0/0x13/0/valid 0; one edge later, 0x100/0x00500093/0x104/valid 1.
- Stall hold: load 0x200, then stall_d = 1 for 3 cycles with pc_in changing to 0x204/0x208/0x20C -> pc_out stays 0x200; stall_cnt = 3; stall_timeout = 0.
- Flush beats stall: stall_d = 1 and flush_d = 1 in the same cycle -> instr_out = 0x13, valid_d = 0, pc_out = 0; flush_cnt += 1; stall_cnt unchanged.
- Invalid fetch: valid_f = 0, instr_in = 0xFFFFFFFF, pc_in = 0x300 -> instr_out = 0x13, valid_d = 0, pc_out = 0x300.
- Watchdog: STALL_LIMIT = 4; stall 3 cycles, one load, then stall 4 cycles -> stall_timeout stays 0 after the first run and goes 1 on the 4th stall edge of the second run; it remains 1 through a later flush until rst.
- Saturation: CNT_W = 3; 10 flush cycles -> flush_cnt reaches 7 and holds; 3 rst cycles mid-sequence -> all counters 0 on the next edge.
